// File: rtl/avr_isa_pkg.sv
// AVR instruction ids, opcode templates and field-packing helpers shared by the
// instruction decoder and the instruction encoder.
package avr_isa_pkg;

  typedef enum logic [1:0] {EMPTY, WORD1, WORD2} encState_e;

  localparam logic [7:0] ID_NOP   = 8'h00, ID_ADC   = 8'h01, ID_ADD   = 8'h02;
  localparam logic [7:0] ID_AND   = 8'h03, ID_BRCC  = 8'h04, ID_BRCS  = 8'h05;
  localparam logic [7:0] ID_BREQ  = 8'h06, ID_BRNE  = 8'h08, ID_CALL  = 8'h09;
  localparam logic [7:0] ID_CLI   = 8'h0A, ID_CP    = 8'h0C, ID_CPI   = 8'h0D;
  localparam logic [7:0] ID_CPSE  = 8'h0E, ID_DEC   = 8'h0F, ID_EOR   = 8'h10;
  localparam logic [7:0] ID_IN    = 8'h11, ID_INC   = 8'h12, ID_JMP   = 8'h13;
  localparam logic [7:0] ID_LD_Y  = 8'h19, ID_LD_YP = 8'h1A, ID_LD_MY = 8'h1B;
  localparam logic [7:0] ID_LDI   = 8'h20, ID_LDS   = 8'h21, ID_LPM   = 8'h22;
  localparam logic [7:0] ID_LSR   = 8'h24, ID_MOV   = 8'h25, ID_MUL   = 8'h26;
  localparam logic [7:0] ID_OR    = 8'h27, ID_ORI   = 8'h28, ID_OUT   = 8'h29;
  localparam logic [7:0] ID_POP   = 8'h2A, ID_PUSH  = 8'h2B, ID_RCALL = 8'h2C;
  localparam logic [7:0] ID_RET   = 8'h2D, ID_RETI  = 8'h2E, ID_RJMP  = 8'h2F;
  localparam logic [7:0] ID_ROR   = 8'h31, ID_SEI   = 8'h32, ID_ST_Y  = 8'h38;
  localparam logic [7:0] ID_ST_YP = 8'h39, ID_ST_MY = 8'h3A, ID_STS   = 8'h3F;
  localparam logic [7:0] ID_SUB   = 8'h40, ID_SUBI  = 8'h41;

  localparam logic [15:0] OPC_ADC  = 16'h1C00, OPC_ADD  = 16'h0C00, OPC_AND = 16'h2000;
  localparam logic [15:0] OPC_CP   = 16'h1400, OPC_CPSE = 16'h1000, OPC_EOR = 16'h2400;
  localparam logic [15:0] OPC_MOV  = 16'h2C00, OPC_MUL  = 16'h9C00, OPC_OR  = 16'h2800;
  localparam logic [15:0] OPC_SUB  = 16'h1800;
  localparam logic [15:0] OPC_BRCC = 16'hF400, OPC_BRCS = 16'hF000;
  localparam logic [15:0] OPC_BREQ = 16'hF001, OPC_BRNE = 16'hF401;
  localparam logic [15:0] OPC_CPI  = 16'h3000, OPC_LDI  = 16'hE000;
  localparam logic [15:0] OPC_ORI  = 16'h6000, OPC_SUBI = 16'h5000;
  localparam logic [15:0] OPC_IN   = 16'hB000, OPC_OUT  = 16'hB800;
  localparam logic [15:0] OPC_ONE  = 16'h9400, OPC_LOAD = 16'h9000, OPC_STORE = 16'h9200;
  localparam logic [15:0] OPC_LD_Y = 16'h8008, OPC_ST_Y = 16'h8208;
  localparam logic [15:0] OPC_CALL = 16'h940E, OPC_JMP  = 16'h940C;
  localparam logic [15:0] OPC_NOP  = 16'h0000, OPC_CLI  = 16'h94F8, OPC_SEI = 16'h9478;
  localparam logic [15:0] OPC_RET  = 16'h9508, OPC_RETI = 16'h9518;
  localparam logic [15:0] OPC_RCALL = 16'hD000, OPC_RJMP = 16'hC000;

  function automatic logic [15:0] rrForm(logic [15:0] opc, logic [4:0] d, logic [4:0] r);
    return opc | {6'b0, r[4], d, r[3:0]};
  endfunction

  function automatic logic [15:0] immForm(logic [15:0] opc, logic [3:0] d, logic [7:0] k);
    return opc | {4'b0, k[7:4], d, k[3:0]};
  endfunction

  function automatic logic [15:0] regForm(logic [15:0] opc, logic [4:0] d, logic [3:0] x);
    return opc | {7'b0, d, x};
  endfunction

  function automatic logic isTwoWord(logic [7:0] id);
    return (id == ID_CALL) || (id == ID_JMP) || (id == ID_LDS) || (id == ID_STS);
  endfunction

endpackage

// File: rtl/instruction_word_builder.sv
// Combinational translation of an (id, arg1, arg2) tuple into the first
// program-memory word, plus the two-word and illegal flags.
module instruction_word_builder
  import avr_isa_pkg::*;
(
  input  logic [7:0]  id,
  input  logic [7:0]  arg1,
  input  logic [7:0]  arg2,
  output logic [15:0] word1,
  output logic        twoWord,
  output logic        illegal
);

  logic [4:0] rd;
  logic [4:0] rr;
  logic [3:0] rdHi;

  assign rd   = arg1[4:0];
  assign rr   = arg2[4:0];
  assign rdHi = arg1[3:0];

  always_comb begin
    word1   = 16'h0000;
    twoWord = isTwoWord(id);
    illegal = 1'b0;
    case (id)
      ID_ADC:   word1 = rrForm(OPC_ADC, rd, rr);
      ID_ADD:   word1 = rrForm(OPC_ADD, rd, rr);
      ID_AND:   word1 = rrForm(OPC_AND, rd, rr);
      ID_CP:    word1 = rrForm(OPC_CP, rd, rr);
      ID_CPSE:  word1 = rrForm(OPC_CPSE, rd, rr);
      ID_EOR:   word1 = rrForm(OPC_EOR, rd, rr);
      ID_MOV:   word1 = rrForm(OPC_MOV, rd, rr);
      ID_MUL:   word1 = rrForm(OPC_MUL, rd, rr);
      ID_OR:    word1 = rrForm(OPC_OR, rd, rr);
      ID_SUB:   word1 = rrForm(OPC_SUB, rd, rr);
      ID_BRCC:  word1 = OPC_BRCC | {6'b0, arg1[6:0], 3'b0};
      ID_BRCS:  word1 = OPC_BRCS | {6'b0, arg1[6:0], 3'b0};
      ID_BREQ:  word1 = OPC_BREQ | {6'b0, arg1[6:0], 3'b0};
      ID_BRNE:  word1 = OPC_BRNE | {6'b0, arg1[6:0], 3'b0};
      ID_CPI:   word1 = immForm(OPC_CPI, rdHi, arg2);
      ID_LDI:   word1 = immForm(OPC_LDI, rdHi, arg2);
      ID_ORI:   word1 = immForm(OPC_ORI, rdHi, arg2);
      ID_SUBI:  word1 = immForm(OPC_SUBI, rdHi, arg2);
      ID_IN:    word1 = OPC_IN  | {5'b0, arg2[5:4], rd, arg2[3:0]};
      ID_OUT:   word1 = OPC_OUT | {5'b0, arg2[5:4], rd, arg2[3:0]};
      ID_DEC:   word1 = regForm(OPC_ONE, rd, 4'hA);
      ID_INC:   word1 = regForm(OPC_ONE, rd, 4'h3);
      ID_LSR:   word1 = regForm(OPC_ONE, rd, 4'h6);
      ID_ROR:   word1 = regForm(OPC_ONE, rd, 4'h7);
      ID_LD_YP: word1 = regForm(OPC_LOAD, rd, 4'h9);
      ID_LD_MY: word1 = regForm(OPC_LOAD, rd, 4'hA);
      ID_LPM:   word1 = regForm(OPC_LOAD, rd, 4'h4);
      ID_POP:   word1 = regForm(OPC_LOAD, rd, 4'hF);
      ID_ST_YP: word1 = regForm(OPC_STORE, rd, 4'h9);
      ID_ST_MY: word1 = regForm(OPC_STORE, rd, 4'hA);
      ID_PUSH:  word1 = regForm(OPC_STORE, rd, 4'hF);
      ID_LD_Y:  word1 = regForm(OPC_LD_Y, rd, 4'h0);
      ID_ST_Y:  word1 = regForm(OPC_ST_Y, rd, 4'h0);
      // k[21:16] lives in arg1[5:0]: bits 21:17 sit at [8:4], bit 16 at [0]
      ID_CALL:  word1 = OPC_CALL | {7'b0, arg1[5:1], 3'b0, arg1[0]};
      ID_JMP:   word1 = OPC_JMP  | {7'b0, arg1[5:1], 3'b0, arg1[0]};
      ID_LDS:   word1 = regForm(OPC_LOAD, rd, 4'h0);
      ID_STS:   word1 = regForm(OPC_STORE, rd, 4'h0);
      ID_NOP:   word1 = OPC_NOP;
      ID_CLI:   word1 = OPC_CLI;
      ID_SEI:   word1 = OPC_SEI;
      ID_RET:   word1 = OPC_RET;
      ID_RETI:  word1 = OPC_RETI;
      ID_RCALL: word1 = OPC_RCALL | {4'b0, arg2[3:0], arg1};
      ID_RJMP:  word1 = OPC_RJMP  | {4'b0, arg2[3:0], arg1};
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// Streaming AVR instruction encoder: accepts one tuple per handshake and emits
// one or two registered program-memory words downstream.
module instruction_encoder
  import avr_isa_pkg::*;
#(
  parameter bit NONE_ILLEGAL_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  instruction_id,
  input  logic [7:0]  argument_1,
  input  logic [7:0]  argument_2,
  input  logic [15:0] ext_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] instruction,
  output logic        part2,
  output logic        illegal
);

  encState_e   state_q;
  logic [15:0] instr_q;
  logic        part2_q;
  logic        illegal_q;
  logic [15:0] extWord_q;
  logic        twoWord_q;

  logic [15:0] builtWord;
  logic        builtTwoWord;
  logic        builtIllegal;
  logic        stallTwo;
  logic        accept;
  logic        load;

  instruction_word_builder u_builder (
    .id      (instruction_id),
    .arg1    (argument_1),
    .arg2    (argument_2),
    .word1   (builtWord),
    .twoWord (builtTwoWord),
    .illegal (builtIllegal)
  );

  assign out_valid   = (state_q != EMPTY);
  assign instruction = instr_q;
  assign part2       = part2_q;
  assign illegal     = illegal_q;

  // The second beat of a two-word instruction must not be overtaken by a new tuple
  assign stallTwo = (state_q == WORD1) && twoWord_q;
  assign in_ready = !out_valid || (out_ready && !stallTwo);
  assign accept   = in_valid && in_ready;
  assign load     = accept && (!builtIllegal || NONE_ILLEGAL_ZERO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      instr_q   <= 16'h0000;
      part2_q   <= 1'b0;
      illegal_q <= 1'b0;
      extWord_q <= 16'h0000;
      twoWord_q <= 1'b0;
    end else if (load) begin
      state_q   <= WORD1;
      instr_q   <= builtWord;
      part2_q   <= 1'b0;
      illegal_q <= builtIllegal;
      extWord_q <= ext_word;
      twoWord_q <= builtTwoWord;
    end else if (out_ready) begin
      case (state_q)
        WORD1: begin
          if (twoWord_q) begin
            state_q   <= WORD2;
            instr_q   <= extWord_q;
            part2_q   <= 1'b1;
            illegal_q <= 1'b0;
          end else begin
            state_q <= EMPTY;
          end
        end
        WORD2:   state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed self-checking bench for instruction_encoder with hand-computed words.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  instruction_id;
  logic [7:0]  argument_1;
  logic [7:0]  argument_2;
  logic [15:0] ext_word;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] instruction;
  logic        part2;
  logic        illegal;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [7:0]  sIds [8] = '{8'h01, 8'h40, 8'h12, 8'h32, 8'h28, 8'h06, 8'h29, 8'h25};
  logic [7:0]  sArg1[8] = '{8'h03, 8'h10, 8'h18, 8'h00, 8'h0F, 8'h01, 8'h11, 8'hE2};
  logic [7:0]  sArg2[8] = '{8'h14, 8'h01, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h20, 8'h1F};
  logic [15:0] sExp [8] = '{16'h1E34, 16'h1901, 16'h9583, 16'h9478,
                            16'h6AF5, 16'hF009, 16'hBD10, 16'h2E2F};

  always #5 clk = ~clk;

  instruction_encoder #(.NONE_ILLEGAL_ZERO(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .instruction_id (instruction_id),
    .argument_1     (argument_1),
    .argument_2     (argument_2),
    .ext_word       (ext_word),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .instruction    (instruction),
    .part2          (part2),
    .illegal        (illegal)
  );

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkWord(input string tag, input logic [15:0] w, input logic p2, input logic ill);
    checkOutput({tag, ".valid"}, {15'b0, out_valid}, 16'h0001);
    checkOutput({tag, ".word"}, instruction, w);
    checkOutput({tag, ".part2"}, {15'b0, part2}, {15'b0, p2});
    checkOutput({tag, ".illegal"}, {15'b0, illegal}, {15'b0, ill});
  endtask

  // Drive a tuple at a falling edge, wait (bounded) for acceptance, return one
  // falling edge after the accepting clock with in_valid dropped.
  task automatic applyStimulus(input logic [7:0] id, input logic [7:0] a1,
                               input logic [7:0] a2, input logic [15:0] ext);
    int waitCycles = 0;
    in_valid       = 1'b1;
    instruction_id = id;
    argument_1     = a1;
    argument_2     = a2;
    ext_word       = ext;
    while (!in_ready && waitCycles < 20) begin
      @(posedge clk);
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("acceptWithinBudget", {15'b0, in_ready}, 16'h0001);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    in_valid       = 1'b0;
    instruction_id = 8'h00;
    argument_1     = 8'h00;
    argument_2     = 8'h00;
    ext_word       = 16'h0000;
    out_ready      = 1'b1;
    #12;
    checkOutput("reset.valid", {15'b0, out_valid}, 16'h0000);
    checkOutput("reset.word", instruction, 16'h0000);
    checkOutput("reset.part2", {15'b0, part2}, 16'h0000);
    checkOutput("reset.illegal", {15'b0, illegal}, 16'h0000);
    checkOutput("reset.inReady", {15'b0, in_ready}, 16'h0001);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(8'h02, 8'h01, 8'h02, 16'h0000);
    checkWord("ADD", 16'h0C12, 1'b0, 1'b0);
    applyStimulus(8'h20, 8'h00, 8'hFF, 16'h0000);
    checkWord("LDI", 16'hEF0F, 1'b0, 1'b0);
    applyStimulus(8'h08, 8'h7F, 8'h00, 16'h0000);
    checkWord("BRNE", 16'hF7F9, 1'b0, 1'b0);
    applyStimulus(8'h2F, 8'hFF, 8'h0F, 16'h0000);
    checkWord("RJMP", 16'hCFFF, 1'b0, 1'b0);
    applyStimulus(8'h11, 8'h05, 8'h3F, 16'h0000);
    checkWord("IN", 16'hB65F, 1'b0, 1'b0);
    applyStimulus(8'h2B, 8'h1F, 8'h00, 16'h0000);
    checkWord("PUSH", 16'h93FF, 1'b0, 1'b0);
    applyStimulus(8'h0A, 8'h00, 8'h00, 16'h0000);
    checkWord("CLI", 16'h94F8, 1'b0, 1'b0);
    applyStimulus(8'h14, 8'h00, 8'h00, 16'h0000);
    checkWord("ILLEGAL", 16'h0000, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("drain1.valid", {15'b0, out_valid}, 16'h0000);

    out_ready = 1'b0;
    applyStimulus(8'h09, 8'h00, 8'h00, 16'h1234);
    checkWord("CALL.w1", 16'h940E, 1'b0, 1'b0);
    checkOutput("CALL.w1.inReady", {15'b0, in_ready}, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkWord($sformatf("CALL.hold%0d", i), 16'h940E, 1'b0, 1'b0);
      checkOutput($sformatf("CALL.hold%0d.inReady", i), {15'b0, in_ready}, 16'h0000);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("CALL.release.inReady", {15'b0, in_ready}, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    checkWord("CALL.w2", 16'h1234, 1'b1, 1'b0);
    checkOutput("CALL.w2.inReady", {15'b0, in_ready}, 16'h0001);
    @(posedge clk);
    @(negedge clk);
    checkOutput("drain2.valid", {15'b0, out_valid}, 16'h0000);

    for (int i = 0; i <= 8; i++) begin
      if (i > 0) checkWord($sformatf("stream%0d", i - 1), sExp[i - 1], 1'b0, 1'b0);
      if (i < 8) begin
        in_valid       = 1'b1;
        instruction_id = sIds[i];
        argument_1     = sArg1[i];
        argument_2     = sArg2[i];
        checkOutput($sformatf("stream%0d.inReady", i), {15'b0, in_ready}, 16'h0001);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("drain3.valid", {15'b0, out_valid}, 16'h0000);

    applyStimulus(8'h13, 8'h3F, 8'h00, 16'hBEEF);
    checkWord("JMP.w1", 16'h95FD, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkWord("JMP.w2", 16'hBEEF, 1'b1, 1'b0);
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midReset.valid", {15'b0, out_valid}, 16'h0000);
    checkOutput("midReset.part2", {15'b0, part2}, 16'h0000);
    checkOutput("midReset.word", instruction, 16'h0000);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    applyStimulus(8'h32, 8'h00, 8'h00, 16'h0000);
    checkWord("SEI", 16'h9478, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("drain4.valid", {15'b0, out_valid}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Streaming AVR instruction encoder, the inverse of the core's instruction decoder.
- Accepts an (instruction_id, argument_1, argument_2, ext_word) tuple over a valid/ready handshake.
- Emits the 16-bit program-memory word(s), one per cycle over a second valid/ready handshake. Two-word instructions emit the opcode word, then ext_word with part2=1.
- Sits between the test-program loader/assembler and program memory; its output is bit-compatible with the decoder input (instruction, part2).

Parameters:
- NONE_ILLEGAL_ZERO, 1, when 1 an unsupported id emits 0x0000 (NOP) with illegal=1; when 0 the id is consumed with no output word.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input tuple valid
- in_ready  out  1  encoder can accept a tuple this cycle
- instruction_id  in  8  decoder id space, 0x00-0x41
- argument_1  in  8  same field meaning as decoder argument_1
- argument_2  in  8  same field meaning as decoder argument_2
- ext_word  in  16  second word for CALL/JMP/LDS/STS (K[15:0] or address)
- out_valid  out  1  instruction word valid
- out_ready  in  1  consumer accepts word
- instruction  out  16  encoded word
- part2  out  1  word is the second word of a 32-bit instruction
- illegal  out  1  word produced from an unsupported id

Behaviour:
- Reset values (async): out_valid=0, instruction=0x0000, part2=0, illegal=0, state=EMPTY, held tuple cleared.
- Field mapping:
  - Rd = arg1[4:0] and Rr = arg2[4:0] for two-register forms. arg1[7:5] and arg2[7:5] are ignored.
  - Immediate forms (CPI/LDI/ORI/SUBI): Rd = 16+arg1[3:0], K = arg2.
  - IN/OUT: reg = arg1[4:0], A = arg2[5:0].
  - Branches: k = arg1[6:0].
  - RJMP/RCALL: k = {arg2[3:0], arg1}.
  - CALL/JMP: k[21:16] = arg1[5:0]; second word = ext_word.
- Encodings (r=Rr, d=Rd, K=imm, k=offset):
  - 01 ADC 0001_11rd, 02 ADD 0000_11rd, 03 AND 0010_00rd, 0C CP 0001_01rd, 0E CPSE 0001_00rd, 10 EOR 0010_01rd, 25 MOV 0010_11rd, 26 MUL 1001_11rd, 27 OR 0010_10rd, 40 SUB 0001_10rd. All take the form xxxx_xxrd dddd rrrr.
  - 04 BRCC 1111_01kk kkkk_k000, 05 BRCS 1111_00.._.000, 06 BREQ 1111_00.._.001, 08 BRNE 1111_01.._.001.
  - 0D CPI 0011, 20 LDI 1110, 28 ORI 0110, 41 SUBI 0101. All take the form xxxx KKKK dddd KKKK.
  - 11 IN 1011_0AAd dddd_AAAA, 29 OUT 1011_1AAr rrrr_AAAA.
  - Single-register, 1001_010d dddd_xxxx: 0F DEC x=1010, 12 INC x=0011, 24 LSR x=0110, 31 ROR x=0111.
  - Load/stack, 1001_000d dddd_xxxx: 1A LD Y+ x=1001, 1B LD -Y x=1010, 22 LPM x=0100, 2A POP x=1111.
  - Store/stack, 1001_001r rrrr_xxxx: 39 ST Y+ x=1001, 3A ST -Y x=1010, 2B PUSH x=1111.
  - Displacement-free Y forms: 19 LD Y 1000_000d dddd_1000, 38 ST Y 1000_001r rrrr_1000.
  - Two-word: 09 CALL 1001_010k kkkk_111k, 13 JMP 1001_010k kkkk_110k, 21 LDS 1001_000d dddd_0000, 3F STS 1001_001d dddd_0000.
  - Fixed words: 00 NOP 0x0000, 0A CLI 0x94F8, 2C RCALL 1101_kkkk.., 2D RET 0x9508, 2E RETI 0x9518, 2F RJMP 1100_kkkk.., 32 SEI 0x9478.
  - Any other id is illegal.
- FSM states: EMPTY, WORD1, WORD2. Outputs are registered.
  - Latency: a tuple accepted in cycle N has word1 valid in N+1.
  - EMPTY + in_valid&in_ready → WORD1: load word1, illegal; latch ext_word and the two_word flag.
  - WORD1 & out_ready:
    - if two_word → WORD2: instruction=ext_word, part2=1, in_ready=0.
    - else, if a new tuple is accepted the same cycle → WORD1 (back-to-back); otherwise → EMPTY.
  - WORD2 & out_ready → WORD1 if a new tuple is accepted the same cycle, else EMPTY.
- in_ready = !out_valid | (out_ready & !(state==WORD1 & two_word)).
  - Full throughput is one word per cycle; a two-word instruction blocks input for one beat.
- When out_valid=1 and out_ready=0, instruction, part2 and illegal hold stable. No input is taken.
- With NONE_ILLEGAL_ZERO=0, an illegal id is accepted (in_ready rules unchanged) and no word is emitted; state stays EMPTY.
- Reset mid-operation: a pending WORD2 is discarded. The consumer must treat a dangling first word as aborted.

Decomposition:
- Shared package avr_isa_pkg:
  - ID_* localparams 0x00-0x41 (shared with the decoder)
  - opcode template constants (OPC_ADD=16'h0C00, etc.)
  - TWO_WORD id set
- Sub-module instruction_word_builder: combinational (id, arg1, arg2) → (word1, two_word, illegal). The encoder wraps it with the FSM and handshakes.

Test Plan:
- ADD id=02, arg1=1, arg2=2, out_ready=1 → 0x0C12 one cycle after accept, part2=0, illegal=0.
- LDI id=20, arg1=0, arg2=0xFF → 0xEF0F; BRNE id=08, arg1=0x7F → 0xF7F9; RJMP arg1=0xFF, arg2=0x0F → 0xCFFF.
- CALL id=09, arg1=0, ext_word=0x1234 → 0x940E (part2=0) then 0x1234 (part2=1); in_ready=0 during the first beat; the decoder re-decodes both words to id 0x09 / 0xFF.
- Backpressure: hold out_ready=0 for 3 cycles mid-CALL → word and part2 stable, in_ready=0; release → second word follows next cycle.
- Illegal id=0x14 with default parameter → 0x0000, illegal=1. Back-to-back stream of 8 single-word ids → 8 words in 8 consecutive cycles.
- Assert rst while in WORD2 → out_valid=0 immediately (async); the next accepted SEI → 0x9478.
